// File: rtl/video_sync_generator.sv
// Raster timing generator: pixel/line counters driven by one of four preset timing sets
// or a programmable user set, with registered syncs, blanking, interrupts and blanked RGB.
module video_sync_generator #(
   parameter int CW   = 9,
   parameter int PIXW = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clken,
   input  logic [2:0]      mode,
   input  logic            cfg_we,
   input  logic [3:0]      cfg_addr,
   input  logic [CW-1:0]   cfg_data,
   input  logic            rasterint_enable,
   input  logic            vretraceint_disable,
   input  logic [CW-1:0]   raster_line,
   input  logic [PIXW-1:0] ri,
   input  logic [PIXW-1:0] gi,
   input  logic [PIXW-1:0] bi,
   output logic [CW-1:0]   hcnt,
   output logic [CW-1:0]   vcnt,
   output logic [PIXW-1:0] ro,
   output logic [PIXW-1:0] go,
   output logic [PIXW-1:0] bo,
   output logic            hsync,
   output logic            vsync,
   output logic            csync,
   output logic            hblank,
   output logic            vblank,
   output logic            int_n,
   output logic            raster_int_in_progress,
   output logic            frame_start,
   output logic [2:0]      mode_active
);

   localparam int NREG = 13;

   // Register order: end_h, end_v, hblank_b/e, hsync_b/e, vblank_b/e, vsync_b/e, vcint, hcint_b/e
   function automatic logic [CW-1:0] preset_val(input logic [2:0] m, input int idx);
      int v;
      v = 0;
      case (idx)
         0:  v = (m == 3'd1) ? 455 : 447;
         1:  v = (m == 3'd1) ? 310 : (m == 3'd2) ? 319 : (m == 3'd3) ? 261 : 311;
         2:  v = 320;
         3:  v = (m == 3'd2) ? 383 : 415;
         4:  v = (m == 3'd2) ? 320 : 344;
         5:  v = (m == 3'd2) ? 351 : 375;
         6:  v = (m == 3'd2) ? 240 : (m == 3'd3) ? 216 : 248;
         7:  v = (m == 3'd2) ? 271 : (m == 3'd3) ? 223 : 255;
         8:  v = (m == 3'd2) ? 240 : (m == 3'd3) ? 216 : 248;
         9:  v = (m == 3'd2) ? 255 : (m == 3'd3) ? 219 : 251;
         10: v = (m == 3'd2) ? 239 : (m == 3'd3) ? 216 : 248;
         11: v = (m == 3'd1) ? 6   : (m == 3'd2) ? 326 : 4;
         12: v = (m == 3'd1) ? 69  : (m == 3'd2) ? 397 : 67;
         default: v = 0;
      endcase
      return CW'(v);
   endfunction

   function automatic logic in_win(input logic [CW-1:0] c, input logic [CW-1:0] b,
                                   input logic [CW-1:0] e);
      return (c >= b) && (c <= e);
   endfunction

   logic [CW-1:0]   shadow_reg [NREG];
   logic [CW-1:0]   act_reg    [NREG];
   logic [CW-1:0]   shadow_wr  [NREG];
   logic [CW-1:0]   set_next   [NREG];
   logic [CW-1:0]   preset_48k [NREG];
   logic [CW-1:0]   hc_reg, vc_reg;
   logic [PIXW-1:0] ro_reg, go_reg, bo_reg;
   logic            hsync_reg, vsync_reg, csync_reg, hblank_reg, vblank_reg;
   logic            int_n_reg, raster_reg, frame_start_reg;
   logic [2:0]      mode_active_reg;
   logic [2:0]      mode_eff;

   assign mode_eff = (mode > 3'd4) ? 3'd0 : mode;

   // Shadow view with the current write folded in, so a write on the wrap tick is copied.
   for (genvar gi = 0; gi < NREG; gi++) begin : g_set
      assign shadow_wr[gi]  = (cfg_we && (cfg_addr == 4'(gi))) ? cfg_data : shadow_reg[gi];
      assign set_next[gi]   = (mode_eff == 3'd4) ? shadow_wr[gi] : preset_val(mode_eff, gi);
      assign preset_48k[gi] = preset_val(3'd0, gi);
   end

   logic [CW-1:0] end_h, end_v, raster_tgt;
   logic          h_end, v_end, wrap;
   logic          hb_win, hs_win, vb_win, vs_win, retrace_hit, raster_hit, blank;

   assign end_h = act_reg[0];
   assign end_v = act_reg[1];
   assign h_end = hc_reg >= end_h;
   assign v_end = vc_reg >= end_v;
   assign wrap  = h_end && v_end;

   assign hb_win = in_win(hc_reg, act_reg[2], act_reg[3]);
   assign hs_win = in_win(hc_reg, act_reg[4], act_reg[5]);
   assign vb_win = in_win(vc_reg, act_reg[6], act_reg[7]);
   assign vs_win = in_win(vc_reg, act_reg[8], act_reg[9]);
   assign blank  = hb_win || vb_win;

   assign retrace_hit = !vretraceint_disable && (vc_reg == act_reg[10])
                        && in_win(hc_reg, act_reg[11], act_reg[12]);

   // Raster line 0 means "the last line of the frame", otherwise fire one line early.
   assign raster_tgt = (raster_line == '0) ? end_v : raster_line - CW'(1);
   assign raster_hit = rasterint_enable && (raster_line <= end_v) && (vc_reg == raster_tgt)
                       && in_win(hc_reg, CW'(256), CW'(319));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hc_reg          <= '0;
         vc_reg          <= '0;
         hsync_reg       <= 1'b1;
         vsync_reg       <= 1'b1;
         csync_reg       <= 1'b1;
         hblank_reg      <= 1'b0;
         vblank_reg      <= 1'b0;
         int_n_reg       <= 1'b1;
         raster_reg      <= 1'b0;
         frame_start_reg <= 1'b0;
         mode_active_reg <= 3'd0;
         ro_reg          <= '0;
         go_reg          <= '0;
         bo_reg          <= '0;
         for (int i = 0; i < NREG; i++) begin
            shadow_reg[i] <= preset_48k[i];
            act_reg[i]    <= preset_48k[i];
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            shadow_reg[i] <= shadow_wr[i];
         end
         frame_start_reg <= 1'b0;
         if (clken) begin
            frame_start_reg <= wrap;
            if (h_end) begin
               hc_reg <= '0;
               vc_reg <= v_end ? '0 : vc_reg + CW'(1);
            end else begin
               hc_reg <= hc_reg + CW'(1);
            end
            if (wrap) begin
               for (int i = 0; i < NREG; i++) begin
                  act_reg[i] <= set_next[i];
               end
               mode_active_reg <= mode_eff;
            end
            hsync_reg  <= ~hs_win;
            vsync_reg  <= ~vs_win;
            csync_reg  <= ~(hs_win || vs_win);
            hblank_reg <= hb_win;
            vblank_reg <= vb_win;
            int_n_reg  <= ~(retrace_hit || raster_hit);
            raster_reg <= raster_hit;
            ro_reg     <= blank ? '0 : ri;
            go_reg     <= blank ? '0 : gi;
            bo_reg     <= blank ? '0 : bi;
         end
      end
   end

   assign hcnt                   = hc_reg;
   assign vcnt                   = vc_reg;
   assign ro                     = ro_reg;
   assign go                     = go_reg;
   assign bo                     = bo_reg;
   assign hsync                  = hsync_reg;
   assign vsync                  = vsync_reg;
   assign csync                  = csync_reg;
   assign hblank                 = hblank_reg;
   assign vblank                 = vblank_reg;
   assign int_n                  = int_n_reg;
   assign raster_int_in_progress = raster_reg;
   assign frame_start            = frame_start_reg;
   assign mode_active            = mode_active_reg;

endmodule

// File: tb/tb_video_sync_generator.sv
// Directed bench for video_sync_generator: one full 48K frame, two user frames,
// then random clock-enable gating with a mid-frame reset.
module tb_video_sync_generator;

   logic       clk = 1'b0;
   logic       rst_n, clken, cfg_we, rasterint_enable, vretraceint_disable;
   logic [2:0] mode;
   logic [3:0] cfg_addr;
   logic [8:0] cfg_data, raster_line;
   logic [2:0] ri, gi, bi;
   logic [8:0] hcnt, vcnt;
   logic [2:0] ro, go, bo, mode_active;
   logic       hsync, vsync, csync, hblank, vblank, int_n, raster_int_in_progress, frame_start;

   int errors = 0;
   int checks = 0;
   int user_set [13] = '{399, 4, 320, 399, 340, 371, 4, 4, 4, 3, 2, 10, 19};

   video_sync_generator #(.CW(9), .PIXW(3)) dut (
      .clk(clk), .rst_n(rst_n), .clken(clken), .mode(mode),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .rasterint_enable(rasterint_enable), .vretraceint_disable(vretraceint_disable),
      .raster_line(raster_line), .ri(ri), .gi(gi), .bi(bi),
      .hcnt(hcnt), .vcnt(vcnt), .ro(ro), .go(go), .bo(bo),
      .hsync(hsync), .vsync(vsync), .csync(csync), .hblank(hblank), .vblank(vblank),
      .int_n(int_n), .raster_int_in_progress(raster_int_in_progress),
      .frame_start(frame_start), .mode_active(mode_active)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end else begin
         $display("ok   %s = %0d", name, act);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clken = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      mode = 3'd0; rasterint_enable = 1'b0; vretraceint_disable = 1'b0;
      raster_line = '0; ri = 3'd5; gi = 3'd3; bi = 3'd6;
      tick();
      tick();
      checks++;
      if ({hcnt, vcnt} !== 18'd0) begin
         errors++; $display("FAIL reset_cnt: got %0d/%0d, expected 0/0", hcnt, vcnt);
      end
      checks++;
      if ({hsync, vsync, csync, hblank, vblank, int_n, raster_int_in_progress, frame_start}
          !== 8'b1110_0100) begin
         errors++;
         $display("FAIL reset_flags: got %b, expected 11100100",
                  {hsync, vsync, csync, hblank, vblank, int_n, raster_int_in_progress, frame_start});
      end
      checks++;
      if ({ro, go, bo, mode_active} !== 12'd0) begin
         errors++; $display("FAIL reset_rgb_mode: got %h, expected 0", {ro, go, bo, mode_active});
      end
      $display("reset checked");
   endtask

   // Full 48K frame; shadow is loaded for the user set and mode changes mid-frame.
   task automatic test_48k_frame();
      int hs_n = 0, hs_first = 0, cs_n = 0, e_int = 0, e_first = 0, e_rip = 0;
      int l_int = 0, l_first = 0, vs_n = 0, vb_n = 0, fs_n = 0, ma_n = 0;
      logic [2:0] rgb_blank = '1;
      rst_n = 1'b1; clken = 1'b1; rasterint_enable = 1'b1; raster_line = 9'd2;
      for (int t = 1; t <= 139776; t++) begin
         cfg_we = 1'b0;
         if (t <= 12) begin
            cfg_we = 1'b1; cfg_addr = 4'(t - 1); cfg_data = 9'(user_set[t - 1]);
         end else if (t == 13) begin
            cfg_we = 1'b1; cfg_addr = 4'd12; cfg_data = 9'd200;
         end else if (t == 14) begin
            cfg_we = 1'b1; cfg_addr = 4'd13; cfg_data = 9'd0;
         end else if (t == 139776) begin
            cfg_we = 1'b1; cfg_addr = 4'd12; cfg_data = 9'd19;
         end
         if (t == 22501) mode = 3'd2;
         if (t == 100000) mode = 3'd4;
         if (t == 801) raster_line = 9'd400;
         tick();
         if (t <= 448 && !hsync) begin hs_n++; if (hs_first == 0) hs_first = t; end
         if (t <= 448 && !csync) cs_n++;
         if (t <= 800) begin
            if (!int_n) begin e_int++; if (e_first == 0) e_first = t; end
            if (raster_int_in_progress) e_rip++;
         end else if (!int_n) begin
            l_int++; if (l_first == 0) l_first = t;
         end
         if (!vsync) vs_n++;
         if (vblank) vb_n++;
         if (t < 139776 && frame_start) fs_n++;
         if (t < 139776 && mode_active != 3'd0) ma_n++;
         if (t == 10) chk("rgb_active", {ro, go, bo}, {3'd5, 3'd3, 3'd6});
         if (t == 330) begin
            rgb_blank = ro | go | bo;
            chk("rgb_in_hblank", rgb_blank, 0);
            chk("hblank_at_330", hblank, 1);
         end
         if (t == 447) chk("hcnt_447", {hcnt, vcnt}, {9'd447, 9'd0});
         if (t == 448) chk("line_wrap", {hcnt, vcnt}, {9'd0, 9'd1});
         if (t == 22500) chk("pos_100_50", {hcnt, vcnt}, {9'd100, 9'd50});
      end
      chk("48k_hsync_low_ticks", hs_n, 32);
      chk("48k_hsync_first", hs_first, 345);
      chk("48k_csync_line0", cs_n, 32);
      chk("48k_raster_low_ticks", e_int, 64);
      chk("48k_raster_first", e_first, 705);
      chk("48k_raster_rip", e_rip, 64);
      chk("48k_retrace_low_ticks", l_int, 64);
      chk("48k_retrace_first", l_first, 111109);
      chk("48k_vsync_low_ticks", vs_n, 1792);
      chk("48k_vblank_ticks", vb_n, 3584);
      chk("48k_no_early_frame_start", fs_n, 0);
      chk("48k_mode_held", ma_n, 0);
      chk("48k_frame_start_at_wrap", frame_start, 1);
      chk("48k_wrap_mode_active", mode_active, 4);
      chk("48k_wrap_counters", {hcnt, vcnt}, 0);
   endtask

   task automatic run_user_frame(input string tag, input int period, input int wr_at,
                                 input int mode_at,
                                 output int hs_n, output int hs_first, output int hb_n,
                                 output int vb_n, output int vs_n, output int cs_n,
                                 output int in_n, output int in_first, output int rip_n,
                                 output int fs_n);
      hs_n = 0; hs_first = 0; hb_n = 0; vb_n = 0; vs_n = 0; cs_n = 0;
      in_n = 0; in_first = 0; rip_n = 0; fs_n = 0;
      for (int u = 1; u <= period; u++) begin
         cfg_we = 1'b0;
         if (u == wr_at) begin cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 9'd349; end
         if (u == mode_at) mode = 3'd7;
         tick();
         if (!hsync) begin hs_n++; if (hs_first == 0) hs_first = u; end
         if (hblank) hb_n++;
         if (vblank) vb_n++;
         if (!vsync) vs_n++;
         if (!csync) cs_n++;
         if (!int_n) begin in_n++; if (in_first == 0) in_first = u; end
         if (raster_int_in_progress) rip_n++;
         if (frame_start) fs_n++;
      end
      $display("%s frame done", tag);
   endtask

   task automatic test_user_mode();
      int hs_n, hs_first, hb_n, vb_n, vs_n, cs_n, in_n, in_first, rip_n, fs_n;
      raster_line = 9'd0; vretraceint_disable = 1'b0;
      run_user_frame("A", 2000, 1000, 0, hs_n, hs_first, hb_n, vb_n, vs_n, cs_n,
                     in_n, in_first, rip_n, fs_n);
      chk("A_hsync_low_ticks", hs_n, 160);
      chk("A_hsync_first", hs_first, 341);
      chk("A_hblank_ticks", hb_n, 400);
      chk("A_vblank_ticks", vb_n, 400);
      chk("A_vsync_empty_window", vs_n, 0);
      chk("A_csync_low_ticks", cs_n, 160);
      chk("A_int_low_ticks", in_n, 74);
      chk("A_int_first_retrace", in_first, 811);
      chk("A_raster_last_line_rip", rip_n, 64);
      chk("A_frame_start_count", fs_n, 1);
      chk("A_period_2000", frame_start, 1);
      chk("A_mode_active", mode_active, 4);
   endtask

   task automatic test_back_to_back();
      int hs_n, hs_first, hb_n, vb_n, vs_n, cs_n, in_n, in_first, rip_n, fs_n;
      raster_line = 9'd3; vretraceint_disable = 1'b1;
      run_user_frame("B", 1750, 0, 500, hs_n, hs_first, hb_n, vb_n, vs_n, cs_n,
                     in_n, in_first, rip_n, fs_n);
      chk("B_hsync_clipped", hs_n, 50);
      chk("B_hsync_first", hs_first, 341);
      chk("B_hblank_clipped", hb_n, 150);
      chk("B_vblank_ticks", vb_n, 350);
      chk("B_raster_only_ticks", in_n, 64);
      chk("B_raster_first", in_first, 957);
      chk("B_rip", rip_n, 64);
      chk("B_frame_start_count", fs_n, 1);
      chk("B_period_1750", frame_start, 1);
      chk("B_mode7_as_48k", mode_active, 0);
      chk("B_wrap_counters", {hcnt, vcnt}, 0);
   endtask

   task automatic test_clken_reset();
      int exp_h = 0, exp_v = 0, freeze_err = 0, cnt_err = 0, guard = 0;
      logic [39:0] snap;
      raster_line = 9'd400; vretraceint_disable = 1'b0;
      while (!(exp_v == 1 && exp_h == 350) && guard < 6000) begin
         guard++;
         snap = {hcnt, vcnt, ro, go, bo, hsync, vsync, csync, hblank, vblank, int_n,
                 raster_int_in_progress, mode_active, 3'b000};
         clken = 1'($urandom_range(0, 1));
         tick();
         if (!clken) begin
            if ({hcnt, vcnt, ro, go, bo, hsync, vsync, csync, hblank, vblank, int_n,
                 raster_int_in_progress, mode_active, 3'b000} !== snap || frame_start !== 1'b0)
               freeze_err++;
         end else begin
            if (exp_h == 447) begin
               exp_h = 0; exp_v = (exp_v == 311) ? 0 : exp_v + 1;
            end else begin
               exp_h++;
            end
            if (hcnt !== 9'(exp_h) || vcnt !== 9'(exp_v)) cnt_err++;
         end
      end
      chk("clken_reached_target", guard < 6000 ? 1 : 0, 1);
      chk("clken_freeze_violations", freeze_err, 0);
      chk("clken_count_errors", cnt_err, 0);
      clken = 1'b1;
      tick();
      chk("pre_reset_hsync_low", hsync, 0);
      chk("pre_reset_hblank", hblank, 1);
      clken = 1'b0; rst_n = 1'b0;
      tick();
      chk("midframe_reset_cnt", {hcnt, vcnt}, 0);
      chk("midframe_reset_flags",
          {hsync, vsync, csync, hblank, vblank, int_n, raster_int_in_progress, frame_start},
          8'b1110_0100);
      chk("midframe_reset_mode", mode_active, 0);
      rst_n = 1'b1; clken = 1'b1;
      tick();
      chk("restart_count", {hcnt, vcnt}, {9'd1, 9'd0});
      chk("restart_hsync", hsync, 1);
   endtask

   initial begin
      test_reset();
      test_48k_frame();
      test_user_mode();
      test_back_to_back();
      test_clken_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
